la_ioinput_filt: RTL and testbench
==================================

// Module: la_ioinput_filt
// PURPOSE
// - N-channel digital input IO with per-channel metastability synchroniser, programmable
//   debounce filter, edge detection and sticky edge flags with aggregated interrupt.
// - Each channel instantiates one la_iobidir pad cell with oe tied 0; filtered outputs
//   feed core logic and the interrupt controller.
// PARAMETERS
// - PROP   "DEFAULT"  cell property, passed to every pad cell
// - SIDE   "NO"       pad ring side: "NO","SO","EA","WE"
// - N      4          channel count, >=1
// - SYNC   2          synchroniser stages, >=2
// - CNTW   8          debounce counter / threshold width
// - CFGW   16         per-channel pad config width
// - RINGW  8          io ring width (shared by all channels)
// PORTS
// - clk       in     1        core clock
// - nreset    in     1        async active-low reset
// - pad       inout  N        input pads
// - vdd,vss,vddio,vssio inout 1 supplies, tied to every pad cell
// - ioring    inout  RINGW    generic io ring, shared
// - cfg       in     N*CFGW   per-channel pad config, ch i = cfg[i*CFGW+:CFGW]
// - ie,pe,ps  in     N        input enable / pull enable / pull select (1=up), per channel
// - thresh    in     N*CNTW   per-channel debounce threshold T
// - rise_en   in     N        enable flag set on rising filtered edge
// - fall_en   in     N        enable flag set on falling filtered edge
// - flag_clr  in     N        clear sticky flag (1-cycle pulse or level)
// - z         out    N        filtered, synchronised input level
// - rise,fall out    N        1-cycle edge pulses of z
// - flag      out    N        sticky edge flags
// - irq       out    1        |flag
// BEHAVIOUR
// - Reset: sync chain, z, cnt, rise, fall, flag, irq all 0. Async assert, sync release.
// - raw[i] = pad cell z output AND ie[i]. ie=0 -> channel settles to z=0 via normal filtering.
// - Synchroniser: SYNC flops; s[i] = last stage. Latency pad->s = SYNC cycles.
// - Debounce per channel, state {z, cnt[CNTW-1:0]}:
//   s==z: cnt<=0.
//   s!=z and (T<=1 or cnt>=T-1): z<=s, cnt<=0.
//   s!=z otherwise: cnt<=cnt+1.
//   -> z follows s after T consecutive differing cycles (T=0 and T=1: 1 cycle).
//   A single-cycle return s==z mid-count discards the count (glitch rejected).
//   Comparison is >= so T lowered mid-count takes effect next cycle; cnt never wraps.
// - Edges: rise asserted the cycle after z 0->1, fall after z 1->0; registered, 1 cycle wide.
// - Flag: set when (rise&rise_en)|(fall&fall_en); cleared by flag_clr; set and clear in
//   the same cycle -> set wins (no lost event). irq registered-free OR of flags.
// - Reset mid-count: all state 0; if s is 1 after release, normal T-cycle filter re-applies.
// - Pad cell cfg/pe/ps pass through unmodified; pad cells are pure combinational paths.
// STRUCTURE
// - No shared package needed; no enums, all widths parameter-derived.
// - Sub-module la_iofilter (#SYNC,CNTW): synchroniser, debounce, edge and flag logic for
//   one channel; top generates N x {la_iobidir, la_iofilter} and ORs flags into irq.
// - Synchroniser flops use the codebase synchroniser cell (la_dsync) where SYNC==2 allows.
// TESTING
// - Reset release, pad=0, T=4 -> z,rise,fall,flag,irq stay 0 for 20 cycles.
// - ch0 T=4, pad 0->1 held -> z rises exactly SYNC+4 cycles after pad edge;
//   rise pulses 1 cycle; flag[0]=1, irq=1 with rise_en=1.
// - ch1 T=4, 3-cycle high glitch -> z,rise,flag unchanged; 4-cycle pulse -> z toggles twice.
// - T=0 on ch2, pad toggles every 3 cycles -> z tracks with SYNC+1 latency, fall on each 1->0.
// - flag_clr and new rise same cycle -> flag stays 1; clr alone next -> flag 0, irq 0.
// - ie[3]=0 with pad=1 -> z[3]=0; nreset asserted mid-count (cnt=2) -> all outputs 0 at once.

Source files
------------

// File: rtl/la_ioinput_filt_pkg.sv
// Shared helpers for the filtered digital input block.
package la_ioinput_filt_pkg;

    // True when the current differing run (cnt + this cycle) has reached thr.
    function automatic logic deb_done(input logic [31:0] cnt, input logic [31:0] thr);
        return (thr <= 32'd1) || (cnt >= thr - 32'd1);
    endfunction

endpackage

// File: rtl/la_dsync.sv
// Two-flop synchroniser cell with asynchronous active-low reset.
module la_dsync (
    input  logic clk,
    input  logic nreset,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];
endmodule

// File: rtl/la_iobidir.sv
// Behavioural bidirectional pad cell; combinational in both directions.
module la_iobidir #(
    parameter string PROP  = "DEFAULT",
    parameter string SIDE  = "NO",
    parameter int    CFGW  = 16,
    parameter int    RINGW = 8
) (
    inout  wire              pad,
    inout  wire              vdd,
    inout  wire              vss,
    inout  wire              vddio,
    inout  wire              vssio,
    inout  wire [RINGW-1:0]  ioring,
    input  logic             a,
    input  logic             ie,
    input  logic             oe,
    input  logic             pe,
    input  logic             ps,
    input  logic [CFGW-1:0]  cfg,
    output logic             z
);
    assign pad = oe ? a : 1'bz;
    assign z   = ie & pad;

    // Supplies, ring, pulls and config only matter to the physical cell.
    logic w_unused;
    assign w_unused = ^{vdd, vss, vddio, vssio, ioring, pe, ps, cfg,
                        (PROP == ""), (SIDE == "")};
endmodule

// File: rtl/la_iofilter.sv
// One input channel: synchroniser, debounce filter, edge pulses and sticky flag.
module la_iofilter
    import la_ioinput_filt_pkg::*;
#(
    parameter int SYNC = 2,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            i_raw,
    input  logic [CNTW-1:0] i_thresh,
    input  logic            i_rise_en,
    input  logic            i_fall_en,
    input  logic            i_flag_clr,
    output logic            o_z,
    output logic            o_rise,
    output logic            o_fall,
    output logic            o_flag
);
    logic w_s;

    if (SYNC == 2) begin : g_dsync
        la_dsync u_sync (
            .clk    (clk),
            .nreset (nreset),
            .i_d    (i_raw),
            .o_q    (w_s)
        );
    end else begin : g_chain
        logic [SYNC-1:0] r_sync;
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC-2:0], i_raw};
            end
        end
        assign w_s = r_sync[SYNC-1];
    end

    logic            r_z, r_zq, r_rise, r_fall, r_flag;
    logic [CNTW-1:0] r_cnt;
    logic            w_done;

    assign w_done = deb_done(32'(r_cnt), 32'(i_thresh));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_z    <= 1'b0;
            r_zq   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_zq   <= r_z;
            r_rise <= r_z & ~r_zq;
            r_fall <= ~r_z & r_zq;
            // A new edge beats a simultaneous clear so no event is lost.
            r_flag <= (r_rise & i_rise_en) | (r_fall & i_fall_en) | (r_flag & ~i_flag_clr);
            if (w_s == r_z) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_z   <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign o_z    = r_z;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_flag = r_flag;
endmodule

// File: rtl/la_ioinput_filt.sv
// N-channel filtered digital input: pad cells, per-channel debounce/edge/flag logic, irq.
module la_ioinput_filt
    import la_ioinput_filt_pkg::*;
#(
    parameter string PROP  = "DEFAULT",
    parameter string SIDE  = "NO",
    parameter int    N     = 4,
    parameter int    SYNC  = 2,
    parameter int    CNTW  = 8,
    parameter int    CFGW  = 16,
    parameter int    RINGW = 8
) (
    input  logic              clk,
    input  logic              nreset,
    inout  wire  [N-1:0]      pad,
    inout  wire               vdd,
    inout  wire               vss,
    inout  wire               vddio,
    inout  wire               vssio,
    inout  wire  [RINGW-1:0]  ioring,
    input  logic [N*CFGW-1:0] cfg,
    input  logic [N-1:0]      ie,
    input  logic [N-1:0]      pe,
    input  logic [N-1:0]      ps,
    input  logic [N*CNTW-1:0] thresh,
    input  logic [N-1:0]      rise_en,
    input  logic [N-1:0]      fall_en,
    input  logic [N-1:0]      flag_clr,
    output logic [N-1:0]      z,
    output logic [N-1:0]      rise,
    output logic [N-1:0]      fall,
    output logic [N-1:0]      flag,
    output logic              irq
);
    logic [N-1:0] w_padz;

    for (genvar i = 0; i < N; i++) begin : g_ch
        la_iobidir #(
            .PROP  (PROP),
            .SIDE  (SIDE),
            .CFGW  (CFGW),
            .RINGW (RINGW)
        ) u_pad (
            .pad    (pad[i]),
            .vdd    (vdd),
            .vss    (vss),
            .vddio  (vddio),
            .vssio  (vssio),
            .ioring (ioring),
            .a      (1'b0),
            .ie     (ie[i]),
            .oe     (1'b0),
            .pe     (pe[i]),
            .ps     (ps[i]),
            .cfg    (cfg[i*CFGW +: CFGW]),
            .z      (w_padz[i])
        );

        la_iofilter #(
            .SYNC (SYNC),
            .CNTW (CNTW)
        ) u_filt (
            .clk        (clk),
            .nreset     (nreset),
            .i_raw      (w_padz[i] & ie[i]),
            .i_thresh   (thresh[i*CNTW +: CNTW]),
            .i_rise_en  (rise_en[i]),
            .i_fall_en  (fall_en[i]),
            .i_flag_clr (flag_clr[i]),
            .o_z        (z[i]),
            .o_rise     (rise[i]),
            .o_fall     (fall[i]),
            .o_flag     (flag[i])
        );
    end

    assign irq = |flag;
endmodule

// File: tb/tb_la_ioinput_filt.sv
// Scoreboard bench: a window-based reference model predicts every cycle's outputs.
module tb_la_ioinput_filt;
    localparam int N = 4, SYNC = 2, CNTW = 8, CFGW = 16, RINGW = 8;

    logic clk = 1'b0;
    logic nreset;
    logic [N-1:0] pad_drv;
    wire  [N-1:0] pad;
    wire vdd, vss, vddio, vssio;
    wire [RINGW-1:0] ioring;
    logic [N*CFGW-1:0] cfg;
    logic [N-1:0] ie, pe, ps, rise_en, fall_en, flag_clr;
    logic [N*CNTW-1:0] thresh;
    logic [N-1:0] z, rise, fall, flag;
    logic irq;

    assign pad    = pad_drv;
    assign vdd    = 1'b1;
    assign vss    = 1'b0;
    assign vddio  = 1'b1;
    assign vssio  = 1'b0;
    assign ioring = '0;

    la_ioinput_filt #(
        .PROP ("DEFAULT"), .SIDE ("NO"), .N (N), .SYNC (SYNC),
        .CNTW (CNTW), .CFGW (CFGW), .RINGW (RINGW)
    ) dut (
        .clk (clk), .nreset (nreset), .pad (pad), .vdd (vdd), .vss (vss),
        .vddio (vddio), .vssio (vssio), .ioring (ioring), .cfg (cfg),
        .ie (ie), .pe (pe), .ps (ps), .thresh (thresh), .rise_en (rise_en),
        .fall_en (fall_en), .flag_clr (flag_clr), .z (z), .rise (rise),
        .fall (fall), .flag (flag), .irq (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] z;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] flag;
        logic         irq;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: raw delay line, history of synchronised samples, recent z values.
    logic [N-1:0] dl [SYNC];
    bit           sh [N][$];
    logic [N-1:0] m_z, m_z1, m_rise, m_fall, m_flag;

    function automatic obs_t model_obs();
        return {m_z, m_rise, m_fall, m_flag, |m_flag};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) dl[k] = '0;
        for (int i = 0; i < N; i++) sh[i].delete();
        m_z = '0; m_z1 = '0; m_rise = '0; m_fall = '0; m_flag = '0;
    endtask

    // z flips once the last max(T,1) synchronised samples all differ from it.
    task automatic model_edge();
        logic [N-1:0] s, nz, nfl;
        s = dl[SYNC-1];
        nz = m_z;
        for (int i = 0; i < N; i++) begin
            int t;
            bit all_diff;
            sh[i].push_back(s[i]);
            if (sh[i].size() > 64) void'(sh[i].pop_front());
            t = int'(thresh[i*CNTW +: CNTW]);
            if (t < 1) t = 1;
            if (sh[i].size() >= t) begin
                all_diff = 1'b1;
                for (int j = 0; j < t; j++)
                    if (sh[i][sh[i].size()-1-j] == m_z[i]) all_diff = 1'b0;
                if (all_diff) nz[i] = ~m_z[i];
            end
        end
        nfl = (m_rise & rise_en) | (m_fall & fall_en) | (m_flag & ~flag_clr);
        for (int k = SYNC-1; k > 0; k--) dl[k] = dl[k-1];
        dl[0] = pad_drv & ie;
        m_rise = m_z & ~m_z1;
        m_fall = ~m_z & m_z1;
        m_z1   = m_z;
        m_z    = nz;
        m_flag = nfl;
    endtask

    always @(posedge clk) begin
        if (nreset) model_edge();
        exp_q.push_back(model_obs());
    end

    always @(negedge clk) begin : monitor
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {z, rise, fall, flag, irq};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t z/rise/fall/flag/irq got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                         $time, a.z, a.rise, a.fall, a.flag, a.irq,
                         e.z, e.rise, e.fall, e.flag, e.irq);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mid-cycle async reset: the expectation queued at this edge becomes the reset state.
    task automatic reset_assert();
        nreset = 1'b0;
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(model_obs());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit found;
        model_reset();
        nreset   = 1'b0;
        pad_drv  = '0;
        ie       = '1;
        pe       = 4'b0101;
        ps       = 4'b0011;
        cfg      = {N*CFGW{1'b0}} | 64'hA5A5_5A5A_1234_8765;
        thresh   = {N{8'd4}};
        rise_en  = '1;
        fall_en  = '1;
        flag_clr = '0;

        wait_cyc(3);
        nreset = 1'b1;
        wait_cyc(20);

        pad_drv[0] = 1'b1;
        wait_cyc(12);

        pad_drv[1] = 1'b1; wait_cyc(3); pad_drv[1] = 1'b0; wait_cyc(10);
        pad_drv[1] = 1'b1; wait_cyc(4); pad_drv[1] = 1'b0; wait_cyc(12);

        thresh[2*CNTW +: CNTW] = '0;
        for (int k = 0; k < 8; k++) begin
            pad_drv[2] = ~pad_drv[2];
            wait_cyc(3);
        end
        wait_cyc(6);

        pad_drv[0] = 1'b0; wait_cyc(10);
        flag_clr = '1; wait_cyc(2); flag_clr = '0;
        pad_drv[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            wait_cyc(1);
            if (rise[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rise0_timeout got no rise within 20 cycles, want one");
        end
        flag_clr[0] = 1'b1;
        wait_cyc(1);
        flag_clr = '1; rise_en = '0; fall_en = '0;
        wait_cyc(1);
        flag_clr = '0;
        wait_cyc(3);
        rise_en = '1; fall_en = '1;

        ie[3] = 1'b0; pad_drv[3] = 1'b1;
        wait_cyc(12);

        pad_drv[1] = 1'b1;
        wait_cyc(SYNC + 2);
        reset_assert();
        wait_cyc(3);
        nreset = 1'b1;
        wait_cyc(12);

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 4) == 0) pad_drv[i] = ~pad_drv[i];
            if (c % 50 == 0)
                for (int i = 0; i < N; i++) thresh[i*CNTW +: CNTW] = CNTW'($urandom_range(0, 7));
            if (c % 20 == 0) begin
                rise_en = N'($urandom);
                fall_en = N'($urandom);
            end
            for (int i = 0; i < N; i++) flag_clr[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 60) == 0) ie[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 400) == 0) begin
                reset_assert();
                wait_cyc(2);
                nreset = 1'b1;
            end
            wait_cyc(1);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
